// File: rtl/pwm_fade_pkg.sv
// Shared definitions for the PWM fade sequencer: FSM state encoding.
package pwm_fade_pkg;

  localparam int unsigned StateW = 3;

  typedef enum logic [StateW-1:0] {
    StIdle   = 3'd0,
    StUp     = 3'd1,
    StHoldHi = 3'd2,
    StDown   = 3'd3,
    StHoldLo = 3'd4
  } fade_state_e;

endpackage

// File: rtl/step_tick_gen.sv
// Step-interval prescaler: counts 0..div and fires tick in the cycle where count == div.
// While clr is high the counter is held at zero and no tick is produced.
module step_tick_gen #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;

  assign tick = ~clr && (cnt_q == div);

  // Free-running prescaler, wraps on tick so every state change (always on a tick) restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_fade_sequencer.sv
// Breathing-duty sequencer: ramps the PWM compare value min -> max -> min in fixed steps,
// holding at each extreme, until stopped.
module pwm_fade_sequencer
  import pwm_fade_pkg::*;
#(
  parameter int unsigned DUTY_W = 8,
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [DUTY_W-1:0] i_duty_min,
  input  logic [DUTY_W-1:0] i_duty_max,
  input  logic [DUTY_W-1:0] i_step,
  input  logic [DIV_W-1:0]  i_step_div,
  input  logic [HOLD_W-1:0] i_hold,
  output logic [DUTY_W-1:0] o_duty,
  output logic              o_duty_upd,
  output logic              o_busy,
  output logic              o_cfg_err
);

  fade_state_e       state_q;
  logic [DUTY_W-1:0] duty_q;
  logic              duty_upd_q;
  logic              busy_q;
  logic              cfg_err_q;
  logic [DUTY_W-1:0] min_q;
  logic [DUTY_W-1:0] max_q;
  logic [DUTY_W-1:0] step_q;
  logic [DIV_W-1:0]  div_q;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              tick;

  // One extra bit so neither the up-sum nor the down-floor can wrap.
  logic [DUTY_W:0]   sum_up;
  logic [DUTY_W:0]   down_floor;
  logic [DUTY_W-1:0] diff_down;

  assign sum_up     = {1'b0, duty_q} + {1'b0, step_q};
  assign down_floor = {1'b0, min_q} + {1'b0, step_q};
  assign diff_down  = duty_q - step_q;

  step_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == StIdle),
    .div  (div_q),
    .tick (tick)
  );

  // Sequencer FSM with registered duty, strobe, busy and config-error outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      duty_q     <= '0;
      duty_upd_q <= 1'b0;
      busy_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      min_q      <= '0;
      max_q      <= '0;
      step_q     <= '0;
      div_q      <= '0;
      hold_q     <= '0;
      hold_cnt_q <= '0;
    end else begin
      duty_upd_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      if (state_q == StIdle) begin
        if (i_start) begin
          if ((i_duty_min >= i_duty_max) || (i_step == '0)) begin
            cfg_err_q <= 1'b1;
          end else begin
            min_q      <= i_duty_min;
            max_q      <= i_duty_max;
            step_q     <= i_step;
            div_q      <= i_step_div;
            hold_q     <= i_hold;
            duty_q     <= i_duty_min;
            duty_upd_q <= 1'b1;
            busy_q     <= 1'b1;
            hold_cnt_q <= '0;
            state_q    <= StUp;
          end
        end
      end else if (i_stop) begin
        // Stop beats tick and start; duty stays frozen.
        state_q    <= StIdle;
        busy_q     <= 1'b0;
        hold_cnt_q <= '0;
      end else if (tick) begin
        case (state_q)
          StUp: begin
            if (sum_up >= {1'b0, max_q}) begin
              duty_q     <= max_q;
              duty_upd_q <= (duty_q != max_q);
              state_q    <= StHoldHi;
            end else begin
              duty_q     <= sum_up[DUTY_W-1:0];
              duty_upd_q <= 1'b1;
            end
          end
          StDown: begin
            if (({1'b0, duty_q} < down_floor) || (diff_down == min_q)) begin
              duty_q     <= min_q;
              duty_upd_q <= (duty_q != min_q);
              state_q    <= StHoldLo;
            end else begin
              duty_q     <= diff_down;
              duty_upd_q <= 1'b1;
            end
          end
          StHoldHi, StHoldLo: begin
            if (hold_cnt_q == hold_q) begin
              hold_cnt_q <= '0;
              state_q    <= (state_q == StHoldHi) ? StDown : StUp;
            end else begin
              hold_cnt_q <= hold_cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_duty     = duty_q;
  assign o_duty_upd = duty_upd_q;
  assign o_busy     = busy_q;
  assign o_cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Self-checking bench for pwm_fade_sequencer: directed scenarios plus randomized sessions,
// compared every cycle against a behavioural model of the fade schedule.
module tb_pwm_fade_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_stop;
  logic [7:0]  i_duty_min, i_duty_max, i_step;
  logic [15:0] i_step_div;
  logic [7:0]  i_hold;
  logic [7:0]  o_duty;
  logic        o_duty_upd, o_busy, o_cfg_err;

  int n_total = 0;
  int n_bad   = 0;

  localparam int PIdle = 0, PUp = 1, PHi = 2, PDn = 3, PLo = 4;

  // Model state
  int m_busy, m_phase, m_since, m_holds, m_duty, m_upd, m_err;
  int c_min, c_max, c_step, c_div, c_hold;

  always #5 clk = ~clk;

  pwm_fade_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_stop     (i_stop),
    .i_duty_min (i_duty_min),
    .i_duty_max (i_duty_max),
    .i_step     (i_step),
    .i_step_div (i_step_div),
    .i_hold     (i_hold),
    .o_duty     (o_duty),
    .o_duty_upd (o_duty_upd),
    .o_busy     (o_busy),
    .o_cfg_err  (o_cfg_err)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_phase = PIdle; m_since = 0; m_holds = 0;
    m_duty = 0; m_upd = 0; m_err = 0;
  endtask

  // Next-edge outcome from the fade rules, using the inputs currently applied.
  task automatic model_step(input bit start, input bit stop);
    int  nd;
    bit  t;
    m_upd = 0;
    m_err = 0;
    if (m_busy == 0) begin
      if (start) begin
        if (int'(i_duty_min) >= int'(i_duty_max) || i_step == 0) begin
          m_err = 1;
        end else begin
          c_min = int'(i_duty_min); c_max = int'(i_duty_max); c_step = int'(i_step);
          c_div = int'(i_step_div); c_hold = int'(i_hold);
          m_duty = c_min; m_upd = 1; m_busy = 1;
          m_phase = PUp; m_since = 0; m_holds = 0;
        end
      end
    end else if (stop) begin
      m_busy = 0;
      m_phase = PIdle;
    end else begin
      t = ((m_since % (c_div + 1)) == c_div);
      m_since++;
      if (t) begin
        if (m_phase == PUp) begin
          nd = m_duty + c_step;
          if (nd >= c_max) begin nd = c_max; m_phase = PHi; m_holds = 0; end
          m_upd = (nd != m_duty);
          m_duty = nd;
        end else if (m_phase == PDn) begin
          nd = m_duty - c_step;
          if (nd <= c_min) begin nd = c_min; m_phase = PLo; m_holds = 0; end
          m_upd = (nd != m_duty);
          m_duty = nd;
        end else begin
          if (m_holds == c_hold) begin
            m_phase = (m_phase == PHi) ? PDn : PUp;
            m_holds = 0;
          end else begin
            m_holds++;
          end
        end
      end
    end
  endtask

  task automatic do_cycle(input bit start, input bit stop);
    i_start = start;
    i_stop  = stop;
    model_step(start, stop);
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_stop  = 1'b0;
    check_eq("duty", o_duty, m_duty);
    check_eq("upd", o_duty_upd, m_upd);
    check_eq("busy", o_busy, m_busy);
    check_eq("cfg_err", o_cfg_err, m_err);
  endtask

  task automatic set_cfg(input int mn, input int mx, input int st, input int dv, input int hd);
    i_duty_min = 8'(mn); i_duty_max = 8'(mx); i_step = 8'(st);
    i_step_div = 16'(dv); i_hold = 8'(hd);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) do_cycle(1'b0, 1'b0);
  endtask

  initial begin
    int guard;
    int mn, mx, tmp;
    rst = 1'b1;
    i_start = 1'b0;
    i_stop  = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    model_reset();
    #12;
    check_eq("rst_duty", o_duty, 0);
    check_eq("rst_upd", o_duty_upd, 0);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_err", o_cfg_err, 0);
    rst = 1'b0;

    // Full breathing cycle with div=3, hold=1
    set_cfg(10, 40, 10, 3, 1);
    do_cycle(1'b1, 1'b0);
    check_eq("s1_start", o_duty, 10);
    check_eq("s1_start_upd", o_duty_upd, 1);
    run(4);
    check_eq("s1_20", o_duty, 20);
    run(19);
    check_eq("s1_hold40", o_duty, 40);
    run(1);
    check_eq("s1_down30", o_duty, 30);
    run(60);
    do_cycle(1'b0, 1'b1);

    // Stop with simultaneous start while at 30 in UP
    do_cycle(1'b1, 1'b0);
    run(8);
    check_eq("s4_at30", o_duty, 30);
    do_cycle(1'b1, 1'b1);
    check_eq("s4_busy", o_busy, 0);
    check_eq("s4_duty", o_duty, 30);
    check_eq("s4_upd", o_duty_upd, 0);
    run(3);

    // Saturating ramp 0..25 step 10
    set_cfg(0, 25, 10, 1, 0);
    do_cycle(1'b1, 1'b0);
    run(40);
    do_cycle(1'b0, 1'b1);

    // No wrap past 255, div=0
    set_cfg(0, 255, 200, 0, 0);
    do_cycle(1'b1, 1'b0);
    check_eq("s3_0", o_duty, 0);
    do_cycle(1'b0, 1'b0);
    check_eq("s3_200", o_duty, 200);
    do_cycle(1'b0, 1'b0);
    check_eq("s3_255", o_duty, 255);
    do_cycle(1'b0, 1'b0);
    do_cycle(1'b0, 1'b0);
    check_eq("s3_55", o_duty, 55);
    do_cycle(1'b0, 1'b0);
    check_eq("s3_min", o_duty, 0);
    do_cycle(1'b0, 1'b1);

    // Rejected configurations
    set_cfg(40, 40, 10, 0, 0);
    do_cycle(1'b1, 1'b0);
    check_eq("s5_err_eq", o_cfg_err, 1);
    check_eq("s5_busy_eq", o_busy, 0);
    set_cfg(5, 9, 0, 0, 0);
    do_cycle(1'b1, 1'b0);
    check_eq("s5_err_step0", o_cfg_err, 1);
    check_eq("s5_duty", o_duty, 0);
    run(2);

    // Async reset mid-DOWN
    set_cfg(0, 25, 10, 0, 0);
    do_cycle(1'b1, 1'b0);
    guard = 0;
    while (m_phase != PDn && guard < 50) begin
      do_cycle(1'b0, 1'b0);
      guard++;
    end
    check_eq("s6_reach_down", (m_phase == PDn) ? 1 : 0, 1);
    do_cycle(1'b0, 1'b0);
    #3 rst = 1'b1;
    #1;
    check_eq("s6_rst_duty", o_duty, 0);
    check_eq("s6_rst_busy", o_busy, 0);
    check_eq("s6_rst_upd", o_duty_upd, 0);
    model_reset();
    #1 rst = 1'b0;
    run(5);

    // Randomized sessions, config inputs also toggled while busy
    for (int s = 0; s < 40; s++) begin
      mn = $urandom_range(0, 200);
      mx = $urandom_range(0, 255);
      if (mx <= mn && $urandom_range(0, 3) != 0) begin tmp = mn; mn = mx; mx = tmp; end
      set_cfg(mn, mx, $urandom_range(0, 80), $urandom_range(0, 3), $urandom_range(0, 3));
      do_cycle(1'b1, 1'b0);
      for (int k = 0; k < 200; k++) begin
        if ($urandom_range(0, 19) == 0) begin
          set_cfg($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 80),
                  $urandom_range(0, 3), $urandom_range(0, 3));
        end
        do_cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 149) == 0));
      end
      do_cycle(1'b0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
